line_coder: RTL
===============

LINE_CODER -- requirements
Module: line_coder

Interface
REQ-001 Parameter MODE, default 1, meaning: 0 = AMI, 1 = HDBn zero substitution.
REQ-002 Parameter ZERO_RUN, default 3, meaning: N, the longest zero run left on the line (HDBn); legal range 2..7.
REQ-003 clk_i  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n_i  input  1  reset, asynchronous assert, active-low.
REQ-005 bit_i  input  1  serial data bit, sampled when valid_i = 1.
REQ-006 valid_i  input  1  input strobe; the pipeline advances only on cycles with valid_i = 1.
REQ-007 code_o  output  2  line symbol: 2'b00 zero, 2'b01 positive pulse, 2'b10 negative pulse; 2'b11 never driven.
REQ-008 valid_o  output  1  code_o holds a new symbol this cycle.

Function
REQ-009 Delay line: N+1 entries, each tagged ZERO, ONE, B or V; shifts by one entry per accepted bit.
REQ-010 Latency: the symbol for accepted bit k is driven, registered, in the cycle after bit k+N+1 is accepted.
REQ-011 valid_o rises only after N+1 bits have been accepted since reset.
REQ-012 After that, valid_o = 1 exactly one cycle after each valid_i = 1 cycle; otherwise valid_o = 0 and code_o holds its last value.
REQ-013 MODE = 0 (AMI):
- ONE emits a pulse of polarity opposite to the last emitted pulse.
- ZERO emits 2'b00.
- No substitution.
REQ-014 MODE = 1, input side: a zero-run counter counts consecutive accepted zeros; an accepted 1 clears it.
REQ-015 MODE = 1, input side: a parity flag toggles on every accepted 1.
REQ-016 MODE = 1, substitution on the zero that completes a run of N+1: newest entry tagged V, run counter cleared.
- Parity even: oldest window entry also tagged B.
- Parity odd: no B.
- Parity flag cleared after every substitution.
REQ-017 Output stage polarity rule:
- ONE and B emit the polarity opposite to last_pol.
- V emits the same polarity as last_pol.
- ZERO emits 2'b00.
- last_pol updates on every pulse emitted.
REQ-018 Back-to-back runs: a run longer than 2(N+1) zeros produces consecutive substitutions with no zero left uncounted between them.
REQ-019 Gaps in valid_i do not break a zero run; only accepted bits are counted.

Reset
REQ-020 While rst_n_i = 0: all delay-line entries ZERO, run counter 0, parity 0, fill count 0, valid_o = 0, code_o = 2'b00, last_pol = negative (so the first pulse is positive).
REQ-021 Reset mid-stream discards all in-flight bits; refill restarts per REQ-011 after release.

Configuration
REQ-022 Macro LINE_CODER_DISPARITY_EN defined adds port disparity_o (output, 8-bit signed), the running pulse balance.
- +1 per positive pulse, -1 per negative pulse.
- Saturates at +127 and -128.
- Reset value 0; updates in the same cycle as code_o.
REQ-023 Macro LINE_CODER_DISPARITY_EN undefined: the port and its logic are absent; all other behaviour is identical.

Verification
REQ-024 MODE = 0, N = 3: bits 1,1,0,1 then four fill zeros -> symbols 01,10,00,01; valid_o is first high on the cycle after the 5th accepted bit.
REQ-025 MODE = 1, N = 3: from reset, bits 0,0,0,0 plus fill -> symbols 01,00,00,01 (B00V, both positive).
REQ-026 MODE = 1, N = 3: bits 1, then eight 0s -> symbols 01,00,00,00,01,10,00,00,10 (000V then B00V).
REQ-027 MODE = 1, N = 3: the REQ-026 stream with valid_i low for 3 cycles between every bit -> identical symbol sequence; valid_o only ever 1-cycle pulses.
REQ-028 Reset asserted after the 6th bit of a stream -> valid_o and code_o go to 0 immediately; after release, bits 1,0,0,0,0 produce 01,00,00,00,01.
REQ-029 With LINE_CODER_DISPARITY_EN, AMI, 300 consecutive 1s -> disparity_o alternates between 1 and 0; 200 ones under forced single-polarity stimulus saturate disparity_o at 127.

Source files
------------

// File: rtl/line_coder_if.sv
// line_coder_if: serial bit input and line-symbol output of line_coder.
interface line_coder_if;
   logic       bit_i;
   logic       valid_i;
   logic [1:0] code_o;
   logic       valid_o;
   modport master (output bit_i, valid_i, input code_o, valid_o);
   modport slave (input bit_i, valid_i, output code_o, valid_o);
endinterface

// File: rtl/line_coder.sv
// line_coder: AMI / HDBn line encoder built on an (N+1)-entry tagged delay line.
// Defining LINE_CODER_DISPARITY_EN adds disparity_o, the saturating running pulse balance.
module line_coder #(
   parameter int MODE     = 1,
   parameter int ZERO_RUN = 3
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   line_coder_if.slave       lc
`ifdef LINE_CODER_DISPARITY_EN
   ,
   output logic signed [7:0] disparity_o
`endif
);
   localparam int N = ZERO_RUN;
   localparam logic [1:0] T_ZERO = 2'd0;
   localparam logic [1:0] T_ONE  = 2'd1;
   localparam logic [1:0] T_B    = 2'd2;
   localparam logic [1:0] T_V    = 2'd3;
   logic [N:0][1:0] win_q, win_d;
   logic [2:0] run_q, run_d;
   logic [3:0] fill_q, fill_d;
   logic [1:0] code_q, code_d;
   logic [1:0] old;
   logic par_q, par_d, pol_q, pol_d, valid_q, valid_d;
   logic sub, full, pulse, pos;
`ifdef LINE_CODER_DISPARITY_EN
   logic signed [7:0] disp_q, disp_d;
`endif
   always_comb begin
      win_d   = win_q;
      run_d   = run_q;
      par_d   = par_q;
      fill_d  = fill_q;
      code_d  = code_q;
      pol_d   = pol_q;
      valid_d = 1'b0;
`ifdef LINE_CODER_DISPARITY_EN
      disp_d  = disp_q;
`endif
      sub   = 1'b0;
      full  = fill_q == 4'(N + 1);
      old   = win_q[N];
      pulse = old != T_ZERO;
      // pol_q = 1 means the last pulse was positive; V repeats it, ONE/B alternate
      pos   = (old == T_V) ? pol_q : ~pol_q;
      if (lc.valid_i) begin
         sub   = (MODE == 1) && !lc.bit_i && run_q == 3'(N);
         win_d = {win_q[N-1:0], lc.bit_i ? T_ONE : T_ZERO};
         if (sub) begin
            win_d[0] = T_V;
            if (!par_q) win_d[N] = T_B;
         end
         run_d  = (MODE == 0 || lc.bit_i || sub) ? 3'd0 : run_q + 3'd1;
         par_d  = sub ? 1'b0 : par_q ^ lc.bit_i;
         fill_d = full ? fill_q : fill_q + 4'd1;
         if (full) begin
            valid_d = 1'b1;
            code_d  = pulse ? (pos ? 2'b01 : 2'b10) : 2'b00;
            pol_d   = pulse ? pos : pol_q;
`ifdef LINE_CODER_DISPARITY_EN
            disp_d  = !pulse ? disp_q :
                      pos ? ((disp_q == 8'sh7f) ? disp_q : disp_q + 8'sd1) :
                            ((disp_q == 8'sh80) ? disp_q : disp_q - 8'sd1);
`endif
         end
      end
   end
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         win_q   <= '0;
         run_q   <= '0;
         par_q   <= 1'b0;
         fill_q  <= '0;
         code_q  <= 2'b00;
         pol_q   <= 1'b0;
         valid_q <= 1'b0;
`ifdef LINE_CODER_DISPARITY_EN
         disp_q  <= '0;
`endif
      end else begin
         win_q   <= win_d;
         run_q   <= run_d;
         par_q   <= par_d;
         fill_q  <= fill_d;
         code_q  <= code_d;
         pol_q   <= pol_d;
         valid_q <= valid_d;
`ifdef LINE_CODER_DISPARITY_EN
         disp_q  <= disp_d;
`endif
      end
   end
   assign lc.code_o  = code_q;
   assign lc.valid_o = valid_q;
`ifdef LINE_CODER_DISPARITY_EN
   assign disparity_o = disp_q;
`endif
endmodule
